// File: rtl/icache_fill_ctrl_pkg.sv
// Shared icache fill-controller definitions: FSM state encoding and the
// line-offset width derived from the block size.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ICACHE_DATA_BLOCK_SIZE
`define ICACHE_DATA_BLOCK_SIZE 64
`endif
`ifndef ICACHE_NUM_SETS
`define ICACHE_NUM_SETS 64
`endif

package icache_fill_ctrl_pkg;

    // Fill FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FILL   = 3'd3,
        ST_REPLAY = 3'd4
    } fill_state_e;

    // Byte-offset bits within a line for the default block size
    localparam int ICACHE_OFFSET_BITS = $clog2(`ICACHE_DATA_BLOCK_SIZE / 8);

    // Byte-offset bits within a line for an arbitrary block size
    function automatic int icache_offset_bits(input int block_bits);
        return $clog2(block_bits / 8);
    endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss/fill controller. On a fetch miss it issues one
// line-aligned DRAM read, writes the single-beat response into the icache,
// replays the read, then releases the fetch stage.
// Optional: define ICACHE_FILL_PERF_CNT_EN to add the miss_count output.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ICACHE_DATA_BLOCK_SIZE
`define ICACHE_DATA_BLOCK_SIZE 64
`endif
`ifndef ICACHE_NUM_SETS
`define ICACHE_NUM_SETS 64
`endif

module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH      = `ADDR_WIDTH,
    parameter int BLOCK_SIZE_BITS = `ICACHE_DATA_BLOCK_SIZE,
    parameter int NUM_SETS        = `ICACHE_NUM_SETS
) (
    input  logic                       clk,
    input  logic                       rst_aH,
    input  logic                       fetch_valid,
    input  logic [ADDR_WIDTH-1:0]      fetch_pc,
    input  logic                       cache_hit,
    output logic [ADDR_WIDTH-1:0]      cache_addr,
    output logic                       cache_we_aL,
    output logic [BLOCK_SIZE_BITS-1:0] cache_wdata,
    output logic                       fetch_stall,
    output logic                       dram_req_valid,
    input  logic                       dram_req_ready,
    output logic [ADDR_WIDTH-1:0]      dram_req_addr,
    input  logic                       dram_resp_valid,
    input  logic [BLOCK_SIZE_BITS-1:0] dram_resp_data
`ifdef ICACHE_FILL_PERF_CNT_EN
    ,
    output logic [31:0]                miss_count
`endif
);

    localparam int OFF_BITS = icache_offset_bits(BLOCK_SIZE_BITS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~OFF_MASK;

    // Reject configurations that cannot form a byte-addressed line
    if (NUM_SETS < 1 || BLOCK_SIZE_BITS < 8) begin : g_bad_cfg
        $error("icache_fill_ctrl: NUM_SETS >= 1 and BLOCK_SIZE_BITS >= 8 required");
    end

    fill_state_e                 state_q;
    logic [ADDR_WIDTH-1:0]       miss_addr_q;
    logic [BLOCK_SIZE_BITS-1:0]  fill_q;
    logic                        req_valid_q;
    logic                        we_n_q;
    logic                        idle_miss;

    assign idle_miss = (state_q == ST_IDLE) && fetch_valid && !cache_hit;

    // Fill FSM; request-valid and write-enable are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst_aH) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= '0;
            fill_q      <= '0;
            req_valid_q <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_valid && !cache_hit) begin
                        miss_addr_q <= fetch_pc & LINE_MASK;
                        req_valid_q <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dram_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dram_resp_valid) begin
                        fill_q  <= dram_resp_data;
                        we_n_q  <= 1'b0;
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    we_n_q  <= 1'b1;
                    state_q <= ST_REPLAY;
                end
                ST_REPLAY: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_valid_q <= 1'b0;
                    we_n_q      <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Icache sees the fetch PC only while idle; otherwise the latched miss line
    always_comb begin
        cache_addr  = (state_q == ST_IDLE) ? fetch_pc : miss_addr_q;
        fetch_stall = idle_miss || (state_q != ST_IDLE);
    end

    assign cache_we_aL    = we_n_q;
    assign cache_wdata    = fill_q;
    assign dram_req_valid = req_valid_q;
    assign dram_req_addr  = miss_addr_q;

`ifdef ICACHE_FILL_PERF_CNT_EN
    logic [31:0] miss_cnt_q;
    logic [31:0] miss_cnt_d;

    // Count IDLE->REQ transitions; wraps naturally at 2^32
    always_comb begin
        miss_cnt_d = miss_cnt_q + 32'(idle_miss);
    end

    // Miss counter register
    always_ff @(posedge clk) begin
        if (rst_aH) miss_cnt_q <= '0;
        else        miss_cnt_q <= miss_cnt_d;
    end

    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed fill scenarios with literal expectations
// plus a transaction-level model checked against the DUT on every cycle.
module tb_icache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_aH = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        cache_hit = 1'b0;
    logic        dram_req_ready = 1'b0;
    logic        dram_resp_valid = 1'b0;
    logic [63:0] dram_resp_data = '0;
    logic [31:0] cache_addr;
    logic        cache_we_aL;
    logic [63:0] cache_wdata;
    logic        fetch_stall;
    logic        dram_req_valid;
    logic [31:0] dram_req_addr;
`ifdef ICACHE_FILL_PERF_CNT_EN
    logic [31:0] miss_count;
`endif

    icache_fill_ctrl #(.ADDR_WIDTH(32), .BLOCK_SIZE_BITS(64), .NUM_SETS(64)) dut (
        .clk(clk), .rst_aH(rst_aH),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .cache_hit(cache_hit),
        .cache_addr(cache_addr), .cache_we_aL(cache_we_aL), .cache_wdata(cache_wdata),
        .fetch_stall(fetch_stall),
        .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
        .dram_req_addr(dram_req_addr),
        .dram_resp_valid(dram_resp_valid), .dram_resp_data(dram_resp_data)
`ifdef ICACHE_FILL_PERF_CNT_EN
        , .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs change just after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one outstanding miss at a time
    bit          m_ok = 1'b0;
    bit          m_busy, m_req, m_have, m_post;
    logic [31:0] m_line = '0;
    logic [63:0] m_buf = '0;
    logic [31:0] m_miss = '0;

    always @(negedge clk) begin
        if (m_ok) begin
            chk("fetch_stall", fetch_stall, m_busy | (fetch_valid & ~cache_hit));
            chk("cache_addr", cache_addr, m_busy ? m_line : fetch_pc);
            chk("cache_we_aL", cache_we_aL, !(m_have && !m_post));
            chk("cache_wdata", cache_wdata, m_buf);
            chk("dram_req_valid", dram_req_valid, m_busy && m_req);
            if (m_busy && m_req) chk("dram_req_addr", dram_req_addr, m_line);
`ifdef ICACHE_FILL_PERF_CNT_EN
            chk("miss_count", miss_count, m_miss);
`endif
        end
        // advance the model to the state after the coming rising edge
        if (rst_aH) begin
            m_ok = 1'b1; m_busy = 0; m_req = 0; m_have = 0; m_post = 0;
            m_line = '0; m_buf = '0; m_miss = '0;
        end else if (!m_busy) begin
            if (fetch_valid && !cache_hit) begin
                m_busy = 1; m_req = 1; m_line = {fetch_pc[31:3], 3'b000};
                m_miss = m_miss + 1;
            end
        end else if (m_req) begin
            if (dram_req_ready) m_req = 0;
        end else if (!m_have) begin
            if (dram_resp_valid) begin m_have = 1; m_post = 0; m_buf = dram_resp_data; end
        end else if (!m_post) begin
            m_post = 1;
        end else begin
            m_busy = 0; m_have = 0; m_post = 0;
        end
    end

    // Full miss with immediate handshake and response, then a hit on replay
    task automatic do_miss(input logic [31:0] pc, input logic [63:0] d);
        tick(); fetch_valid = 1; fetch_pc = pc; cache_hit = 0; dram_req_ready = 1;
        tick();
        tick(); dram_resp_valid = 1; dram_resp_data = d;
        tick(); dram_resp_valid = 0;
        tick(); cache_hit = 1;
        tick(); fetch_valid = 0;
    endtask

    task automatic do_hit(input logic [31:0] pc);
        tick(); fetch_valid = 1; fetch_pc = pc; cache_hit = 1;
        tick(); fetch_valid = 0;
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        rst_aH = 0;
        @(negedge clk);
        chk("rst_req_valid", dram_req_valid, 0);
        chk("rst_we", cache_we_aL, 1);
        chk("rst_wdata", cache_wdata, 0);
        chk("rst_req_addr", dram_req_addr, 0);
        chk("rst_stall", fetch_stall, 0);

        // hit in IDLE
        tick(); fetch_valid = 1; fetch_pc = 32'h40; cache_hit = 1;
        @(negedge clk);
        chk("hit_stall", fetch_stall, 0);
        chk("hit_we", cache_we_aL, 1);
        chk("hit_addr", cache_addr, 32'h40);
        tick();
        @(negedge clk);
        chk("hit_no_req", dram_req_valid, 0);

        // miss at 0x1234, ready at once, response two cycles after acceptance
        tick(); fetch_pc = 32'h1234; cache_hit = 0; dram_req_ready = 1;   // cycle 0
        @(negedge clk); chk("miss_stall", fetch_stall, 1);
        tick();                                                            // 1 REQ
        @(negedge clk);
        chk("req_valid", dram_req_valid, 1);
        chk("req_addr", dram_req_addr, 32'h1230);
        tick();                                                            // 2 WAIT
        @(negedge clk); chk("wait_no_req", dram_req_valid, 0);
        tick();                                                            // 3 WAIT
        tick(); dram_resp_valid = 1; dram_resp_data = 64'hDEAD_BEEF_0123_4567; // 4
        tick(); dram_resp_valid = 0;                                       // 5 FILL
        @(negedge clk);
        chk("fill_we", cache_we_aL, 0);
        chk("fill_addr", cache_addr, 32'h1230);
        chk("fill_wdata", cache_wdata, 64'hDEAD_BEEF_0123_4567);
        tick(); cache_hit = 1;                                             // 6 REPLAY
        @(negedge clk);
        chk("replay_we", cache_we_aL, 1);
        chk("replay_addr", cache_addr, 32'h1230);
        chk("replay_stall", fetch_stall, 1);
        tick();                                                            // 7 IDLE
        @(negedge clk); chk("unstall_c7", fetch_stall, 0);

        // ready held low 5 cycles; fetch_pc wanders meanwhile
        tick(); fetch_pc = 32'h300C; cache_hit = 0; dram_req_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); fetch_pc = 32'h5550 + i;
            @(negedge clk);
            chk("hold_req_valid", dram_req_valid, 1);
            chk("hold_req_addr", dram_req_addr, 32'h3008);
        end
        tick(); dram_req_ready = 1;
        tick(); dram_req_ready = 0; fetch_pc = 32'h2000; fetch_valid = 0;  // WAIT
        @(negedge clk); chk("wait_addr", cache_addr, 32'h3008);
        tick(); fetch_valid = 1; dram_resp_valid = 1; dram_resp_data = 64'h1111_2222_3333_4444;
        tick(); dram_resp_valid = 0;
        @(negedge clk);
        chk("fill2_addr", cache_addr, 32'h3008);
        chk("fill2_we", cache_we_aL, 0);
        chk("fill2_wdata", cache_wdata, 64'h1111_2222_3333_4444);
        tick();
        @(negedge clk); chk("replay2_addr", cache_addr, 32'h3008);
        tick(); cache_hit = 1;
        @(negedge clk);
        chk("idle2_addr", cache_addr, 32'h2000);
        chk("idle2_stall", fetch_stall, 0);

        // response while IDLE is ignored
        tick(); fetch_valid = 0; dram_resp_valid = 1; dram_resp_data = 64'hBAD;
        tick(); dram_resp_valid = 0;
        @(negedge clk);
        chk("idle_resp_we", cache_we_aL, 1);
        chk("idle_resp_wdata", cache_wdata, 64'h1111_2222_3333_4444);

        // reset held 3 cycles during WAIT, late response ignored
        tick(); fetch_valid = 1; cache_hit = 0; fetch_pc = 32'h7777_0010; dram_req_ready = 1;
        tick();
        tick();
        @(negedge clk); chk("pre_rst_stall", fetch_stall, 1);
        tick(); rst_aH = 1;
        repeat (2) tick();
        tick(); rst_aH = 0; fetch_valid = 0; dram_resp_valid = 1; dram_resp_data = 64'hCAFE;
        @(negedge clk);
        chk("wrst_req_valid", dram_req_valid, 0);
        chk("wrst_we", cache_we_aL, 1);
        chk("wrst_wdata", cache_wdata, 0);
        chk("wrst_req_addr", dram_req_addr, 0);
        tick(); dram_resp_valid = 0;
        @(negedge clk);
        chk("late_resp_we", cache_we_aL, 1);
        chk("late_resp_wdata", cache_wdata, 0);
        chk("late_resp_stall", fetch_stall, 0);

        // reset during FILL
        tick(); fetch_valid = 1; fetch_pc = 32'h88; cache_hit = 0; dram_req_ready = 1;
        tick();
        tick(); dram_resp_valid = 1; dram_resp_data = 64'h5A5A;
        tick(); dram_resp_valid = 0; rst_aH = 1;
        @(negedge clk); chk("mid_fill_we", cache_we_aL, 0);
        tick(); rst_aH = 0; fetch_valid = 0;
        @(negedge clk);
        chk("mfrst_we", cache_we_aL, 1);
        chk("mfrst_wdata", cache_wdata, 0);
        chk("mfrst_stall", fetch_stall, 0);

        // 3 misses and 2 hits since the last reset
        do_miss(32'h0000_0101, 64'h0101);
        do_hit(32'h0000_0200);
        do_miss(32'h0000_0307, 64'h0307);
        do_hit(32'h0000_0400);
        do_miss(32'hFFFF_FFFF, 64'hFFFF);
        @(negedge clk);
        chk("last_line_wdata", cache_wdata, 64'hFFFF);
`ifdef ICACHE_FILL_PERF_CNT_EN
        chk("miss_count_3", miss_count, 3);
`endif

        // mixed traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            tick();
            fetch_valid     = $urandom_range(0, 1) == 1;
            fetch_pc        = $urandom;
            cache_hit       = $urandom_range(0, 2) == 0;
            dram_req_ready  = $urandom_range(0, 2) != 0;
            dram_resp_valid = $urandom_range(0, 2) == 0;
            dram_resp_data  = {$urandom, $urandom};
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
